// File: rtl/screen_draw_ctrl_pkg.sv
// Shared definitions for the full-screen draw sequencer.
// - state_t   : controller states
// - SID_*     : screen_id codes reported once a screen is complete
// - SEL_*     : drawer select codes for draw_stream_mux
// - SCREEN_*  : screen geometry
package screen_draw_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_CLR       = 3'd0,
        ST_DRAW_BG   = 3'd1,
        ST_PLAY      = 3'd2,
        ST_DRAW_LOSE = 3'd3,
        ST_DRAW_WIN  = 3'd4,
        ST_SHOW      = 3'd5
    } state_t;

    localparam logic [1:0] SID_NONE = 2'd0;
    localparam logic [1:0] SID_BG   = 2'd1;
    localparam logic [1:0] SID_LOSE = 2'd2;
    localparam logic [1:0] SID_WIN  = 2'd3;

    localparam logic [1:0] SEL_BG   = 2'd0;
    localparam logic [1:0] SEL_LOSE = 2'd1;
    localparam logic [1:0] SEL_WIN  = 2'd2;

    localparam int SCREEN_W      = 160;
    localparam int SCREEN_H      = 120;
    localparam int SCREEN_PIXELS = SCREEN_W * SCREEN_H;

endpackage

// File: rtl/draw_stream_mux.sv
// 3-way pixel stream select: routes one drawer's x/y/colour onto a shared
// write port. Purely combinational; reusable for sprite drawers.
// Ports:
//   sel                    drawer select (SEL_BG / SEL_LOSE / SEL_WIN)
//   bg_*, lose_*, win_*    drawer pixel streams
//   out_x, out_y, out_colour  selected stream
module draw_stream_mux (
    input  logic [1:0] sel,
    input  logic [7:0] bg_x,
    input  logic [6:0] bg_y,
    input  logic [8:0] bg_colour,
    input  logic [7:0] lose_x,
    input  logic [6:0] lose_y,
    input  logic [8:0] lose_colour,
    input  logic [7:0] win_x,
    input  logic [6:0] win_y,
    input  logic [8:0] win_colour,
    output logic [7:0] out_x,
    output logic [6:0] out_y,
    output logic [8:0] out_colour
);
    import screen_draw_ctrl_pkg::*;

    always_comb begin
        out_x      = bg_x;
        out_y      = bg_y;
        out_colour = bg_colour;
        case (sel)
            SEL_LOSE: begin
                out_x      = lose_x;
                out_y      = lose_y;
                out_colour = lose_colour;
            end
            SEL_WIN: begin
                out_x      = win_x;
                out_y      = win_y;
                out_colour = win_colour;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/screen_draw_ctrl.sv
// Full-screen draw sequencer sitting in front of the VGA adapter.
// Runs the background draw after reset/restart and the LOSE or WIN screen on
// game end, enabling one drawer at a time and muxing its stream to the VGA
// write port. Drawers are cleared (draw_resetn low) for one cycle before each
// draw because their done flags are sticky.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   lose_evt, win_evt, restart  game events (sampled in PLAY / SHOW)
//   *_done, *_x, *_y, *_colour  drawer streams and completion flags
//   draw_resetn                 active-low clear to all drawers
//   *_enable                    drawer enables
//   vga_x/y/colour, vga_plot    VGA write port
//   busy                        clearing or drawing
//   screen_id                   last completed screen (SID_*)
//   timeout_err                 sticky watchdog flag
module screen_draw_ctrl #(
    parameter int SCREEN_PIXELS  = screen_draw_ctrl_pkg::SCREEN_PIXELS,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int CNT_W          = 15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       lose_evt,
    input  logic       win_evt,
    input  logic       restart,
    input  logic       bg_done,
    input  logic       lose_done,
    input  logic       win_done,
    input  logic [7:0] bg_x,
    input  logic [7:0] lose_x,
    input  logic [7:0] win_x,
    input  logic [6:0] bg_y,
    input  logic [6:0] lose_y,
    input  logic [6:0] win_y,
    input  logic [8:0] bg_colour,
    input  logic [8:0] lose_colour,
    input  logic [8:0] win_colour,
    output logic       draw_resetn,
    output logic       bg_enable,
    output logic       lose_enable,
    output logic       win_enable,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [8:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic [1:0] screen_id,
    output logic       timeout_err
);
    import screen_draw_ctrl_pkg::*;

    if (TIMEOUT_CYCLES <= SCREEN_PIXELS + 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must exceed SCREEN_PIXELS+2");
    end
    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    // Drawer idles one cycle after enable, then its ROM adds one more, so
    // the first valid pixel appears at cnt==2.
    localparam logic [CNT_W-1:0] PLOT_START = CNT_W'(2);
    localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nx, target, target_nx, exit_state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       screen_id_nx, exit_sid, sel;
    logic             timeout_nx, in_draw, cur_done, wd_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_CLR;
            target      <= ST_DRAW_BG;
            cnt         <= '0;
            screen_id   <= SID_NONE;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            target      <= target_nx;
            cnt         <= in_draw ? cnt + 1'b1 : '0;
            screen_id   <= screen_id_nx;
            timeout_err <= timeout_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        target_nx    = target;
        screen_id_nx = screen_id;
        timeout_nx   = timeout_err;
        draw_resetn  = 1'b1;
        bg_enable    = 1'b0;
        lose_enable  = 1'b0;
        win_enable   = 1'b0;
        vga_plot     = 1'b0;
        sel          = SEL_BG;
        in_draw      = 1'b0;
        cur_done     = 1'b0;
        wd_hit       = 1'b0;
        exit_state   = ST_PLAY;
        exit_sid     = SID_BG;

        case (state)
            ST_CLR: begin
                draw_resetn = 1'b0;
                state_nx    = target;
            end
            ST_DRAW_BG: begin
                in_draw    = 1'b1;
                bg_enable  = 1'b1;
                sel        = SEL_BG;
                cur_done   = bg_done;
                exit_state = ST_PLAY;
                exit_sid   = SID_BG;
            end
            ST_DRAW_LOSE: begin
                in_draw     = 1'b1;
                lose_enable = 1'b1;
                sel         = SEL_LOSE;
                cur_done    = lose_done;
                exit_state  = ST_SHOW;
                exit_sid    = SID_LOSE;
            end
            ST_DRAW_WIN: begin
                in_draw    = 1'b1;
                win_enable = 1'b1;
                sel        = SEL_WIN;
                cur_done   = win_done;
                exit_state = ST_SHOW;
                exit_sid   = SID_WIN;
            end
            ST_PLAY: begin
                // lose has priority over a simultaneous win
                if (lose_evt) begin
                    target_nx = ST_DRAW_LOSE;
                    state_nx  = ST_CLR;
                end else if (win_evt) begin
                    target_nx = ST_DRAW_WIN;
                    state_nx  = ST_CLR;
                end
            end
            ST_SHOW: begin
                if (restart) begin
                    target_nx = ST_DRAW_BG;
                    state_nx  = ST_CLR;
                end
            end
            default: begin
                state_nx  = ST_CLR;
                target_nx = ST_DRAW_BG;
            end
        endcase

        // Shared draw-state handling. The done cycle carries the last pixel,
        // so it still plots; a watchdog exit does not. A done seen before
        // cnt==2 exits without plotting.
        if (in_draw) begin
            wd_hit   = (cnt == WD_LAST) && !cur_done;
            vga_plot = (cnt >= PLOT_START) && !wd_hit;
            if (cur_done || wd_hit) begin
                state_nx     = exit_state;
                screen_id_nx = exit_sid;
                timeout_nx   = timeout_err | wd_hit;
            end
        end
    end

    assign busy = in_draw || (state == ST_CLR);

    draw_stream_mux u_mux (
        .sel         (sel),
        .bg_x        (bg_x),
        .bg_y        (bg_y),
        .bg_colour   (bg_colour),
        .lose_x      (lose_x),
        .lose_y      (lose_y),
        .lose_colour (lose_colour),
        .win_x       (win_x),
        .win_y       (win_y),
        .win_colour  (win_colour),
        .out_x       (vga_x),
        .out_y       (vga_y),
        .out_colour  (vga_colour)
    );

endmodule

// File: tb/tb_screen_draw_ctrl.sv
// Bench for screen_draw_ctrl. Drawers are modelled behaviourally: each counts
// its enabled cycles since the last clear; pixel index = count-2 and done is
// raised once the whole screen has been presented. The checker expects the
// k-th plot of a draw to be pixel k in raster order with the drawer's colour.
module tb_screen_draw_ctrl;

    localparam int PIX = 19200;
    localparam int W   = 160;

    logic       clk, resetn, lose_evt, win_evt, restart;
    logic       bg_done, lose_done, win_done;
    logic [7:0] bg_x, lose_x, win_x;
    logic [6:0] bg_y, lose_y, win_y;
    logic [8:0] bg_colour, lose_colour, win_colour;
    logic       draw_resetn, bg_enable, lose_enable, win_enable;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [8:0] vga_colour;
    logic       vga_plot, busy, timeout_err;
    logic [1:0] screen_id;

    int checks   = 0;
    int failures = 0;

    logic [8:0] salt [3];
    logic       win_hang;
    int         en_cnt [3];
    logic [2:0] en_vec, done_vec;

    screen_draw_ctrl dut (
        .clk(clk), .resetn(resetn),
        .lose_evt(lose_evt), .win_evt(win_evt), .restart(restart),
        .bg_done(bg_done), .lose_done(lose_done), .win_done(win_done),
        .bg_x(bg_x), .lose_x(lose_x), .win_x(win_x),
        .bg_y(bg_y), .lose_y(lose_y), .win_y(win_y),
        .bg_colour(bg_colour), .lose_colour(lose_colour), .win_colour(win_colour),
        .draw_resetn(draw_resetn),
        .bg_enable(bg_enable), .lose_enable(lose_enable), .win_enable(win_enable),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .screen_id(screen_id), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pix(int c);
        return (c >= 2) ? c - 2 : 0;
    endfunction

    function automatic logic [8:0] ref_colour(logic [8:0] s, int d, int k);
        return 9'(k * int'(s) + d * 37);
    endfunction

    assign en_vec   = {win_enable, lose_enable, bg_enable};
    assign done_vec = {win_done, lose_done, bg_done};

    // Behavioural drawers: cleared by resetn or draw_resetn, advance while enabled.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) en_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (!draw_resetn)   en_cnt[i] <= 0;
                else if (en_vec[i]) en_cnt[i] <= en_cnt[i] + 1;
        end
    end

    assign bg_x        = 8'(pix(en_cnt[0]) % W);
    assign bg_y        = 7'(pix(en_cnt[0]) / W);
    assign bg_colour   = ref_colour(salt[0], 0, pix(en_cnt[0]));
    assign bg_done     = en_cnt[0] >= PIX + 1;
    assign lose_x      = 8'(pix(en_cnt[1]) % W);
    assign lose_y      = 7'(pix(en_cnt[1]) / W);
    assign lose_colour = ref_colour(salt[1], 1, pix(en_cnt[1]));
    assign lose_done   = en_cnt[1] >= PIX + 1;
    assign win_x       = 8'(pix(en_cnt[2]) % W);
    assign win_y       = 7'(pix(en_cnt[2]) / W);
    assign win_colour  = ref_colour(salt[2], 2, pix(en_cnt[2]));
    assign win_done    = !win_hang && (en_cnt[2] >= PIX + 1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Random event noise while drawing; must be ignored. Quiet near the exit
    // so nothing is pending when PLAY/SHOW is reached.
    task automatic noise(input int n);
        if (n < PIX - 200) begin
            lose_evt = 1'($urandom);
            win_evt  = 1'($urandom);
            restart  = 1'($urandom);
        end else begin
            lose_evt = 1'b0;
            win_evt  = 1'b0;
            restart  = 1'b0;
        end
    endtask

    // Waits for the clear cycle and checks it is exactly one cycle long.
    task automatic wait_clr(input string tag);
        int clr = 0;
        for (int i = 0; i < 8 && draw_resetn !== 1'b0; i++) @(negedge clk);
        while (draw_resetn === 1'b0 && clr < 8) begin
            clr++;
            @(negedge clk);
        end
        check({tag, "_clr_len"}, clr, 1);
    endtask

    task automatic do_draw(input int d, input int exp_en, input int exp_plots,
                           input logic [1:0] exp_sid, input logic err_in,
                           input logic err_out, input bit full, input string tag);
        int en_cycles = 0, plots = 0, bad_pix = 0, bad_other = 0, bad_misc = 0;
        logic       last_done = 1'bx;
        logic [7:0] fx = 'x, lx = 'x;
        logic [6:0] fy = 'x, ly = 'x;
        wait_clr(tag);
        for (int i = 0; i < 25000; i++) begin
            if (en_vec[d] !== 1'b1) break;
            en_cycles++;
            if ((en_vec & ~(3'b001 << d)) !== 3'b000) bad_other++;
            if (busy !== 1'b1 || timeout_err !== err_in || draw_resetn !== 1'b1) bad_misc++;
            if (vga_plot === 1'b1) begin
                if (vga_x !== 8'(plots % W) || vga_y !== 7'(plots / W) ||
                    vga_colour !== ref_colour(salt[d], d, plots)) bad_pix++;
                if (plots == 0) begin fx = vga_x; fy = vga_y; end
                lx = vga_x;
                ly = vga_y;
                last_done = done_vec[d];
                plots++;
            end else if (vga_plot !== 1'b0) bad_pix++;
            noise(en_cycles);
            @(negedge clk);
        end
        check({tag, "_enable_cycles"}, en_cycles, exp_en);
        check({tag, "_plot_count"}, plots, exp_plots);
        check({tag, "_pixel_errs"}, bad_pix, 0);
        check({tag, "_other_enable"}, bad_other, 0);
        check({tag, "_busy_err_flags"}, bad_misc, 0);
        check({tag, "_first_x"}, fx, 0);
        check({tag, "_first_y"}, fy, 0);
        if (full) begin
            check({tag, "_last_x"}, lx, 159);
            check({tag, "_last_y"}, ly, 119);
            check({tag, "_last_with_done"}, last_done, 1);
        end
        check({tag, "_screen_id"}, screen_id, exp_sid);
        check({tag, "_timeout_err"}, timeout_err, err_out);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_plot_after"}, vga_plot, 0);
    endtask

    // Random number of idle cycles in PLAY/SHOW with no events.
    task automatic idle(input logic [1:0] exp_sid, input string tag);
        int bad = 0;
        int n = $urandom_range(1, 20);
        for (int i = 0; i < n; i++) begin
            if (busy !== 1'b0 || screen_id !== exp_sid || en_vec !== 3'b000) bad++;
            @(negedge clk);
        end
        check({tag, "_idle"}, bad, 0);
    endtask

    initial begin
        int bad;
        resetn   = 1'b0;
        lose_evt = 1'b0;
        win_evt  = 1'b0;
        restart  = 1'b0;
        win_hang = 1'b0;
        for (int i = 0; i < 3; i++) salt[i] = 9'($urandom_range(1, 511) | 1);

        repeat (3) @(negedge clk);
        check("rst_enables", en_vec, 0);
        check("rst_plot", vga_plot, 0);
        check("rst_draw_resetn", draw_resetn, 0);
        check("rst_screen_id", screen_id, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_busy", busy, 1);

        // Reset release: clear, full background, then PLAY.
        resetn = 1'b1;
        do_draw(0, PIX + 2, PIX, 2'd1, 1'b0, 1'b0, 1'b1, "bg0");
        idle(2'd1, "play0");

        // WIN drawer never finishes: watchdog exit to SHOW.
        win_hang = 1'b1;
        win_evt  = 1'b1;
        @(negedge clk);
        win_evt = 1'b0;
        do_draw(2, 20000, 20000 - 3, 2'd3, 1'b0, 1'b1, 1'b0, "win_to");
        win_hang = 1'b0;

        // SHOW ignores game events.
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            win_evt  = 1'b1;
            lose_evt = 1'($urandom);
            @(negedge clk);
            if (busy !== 1'b0 || draw_resetn !== 1'b1 || screen_id !== 2'd3) bad++;
        end
        win_evt  = 1'b0;
        lose_evt = 1'b0;
        check("show_ignore", bad, 0);

        // Restart: normal background draw, sticky error stays set.
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        do_draw(0, PIX + 2, PIX, 2'd1, 1'b1, 1'b1, 1'b1, "bg_restart");
        idle(2'd1, "play1");

        // Simultaneous lose+win: LOSE drawn; reset asserted 5000 cycles in.
        lose_evt = 1'b1;
        win_evt  = 1'b1;
        @(negedge clk);
        lose_evt = 1'b0;
        win_evt  = 1'b0;
        wait_clr("lose");
        bad = 0;
        for (int k = 0; k < 5000; k++) begin
            if (en_vec !== 3'b010 || busy !== 1'b1) bad++;
            if (k >= 2 && (vga_plot !== 1'b1 || vga_x !== 8'((k - 2) % W) ||
                           vga_y !== 7'((k - 2) / W) ||
                           vga_colour !== ref_colour(salt[1], 1, k - 2))) bad++;
            if (k < 2 && vga_plot !== 1'b0) bad++;
            noise(k);
            @(negedge clk);
        end
        noise(PIX);
        check("lose_partial", bad, 0);
        check("lose_err_kept", timeout_err, 1);
        #1 resetn = 1'b0;
        #1;
        check("midrst_enables", en_vec, 0);
        check("midrst_plot", vga_plot, 0);
        check("midrst_draw_resetn", draw_resetn, 0);
        check("midrst_screen_id", screen_id, 0);
        check("midrst_timeout_err", timeout_err, 0);
        @(negedge clk);
        resetn = 1'b1;
        do_draw(0, PIX + 2, PIX, 2'd1, 1'b0, 1'b0, 1'b1, "bg_post_rst");
        idle(2'd1, "play2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
